// File: rtl/dram_write_burst_if.sv
// dram_write_burst_if: user write stream plus Avalon-MM write port of the burst write initiator
interface dram_write_burst_if #(
    parameter int MAXBURST_LOG   = 4,
    parameter int WRITENUM_SIZE  = 31,
    parameter int DRAM_ADDRSPACE = 32,
    parameter int DRAM_DATAWIDTH = 512
);
    logic                          WRITE_REQ;
    logic [DRAM_ADDRSPACE-1:0]     WRITE_INITADDR;
    logic [WRITENUM_SIZE:0]        WRITE_NUM;
    logic [DRAM_DATAWIDTH-1:0]     WRITE_DATA;
    logic                          WRITE_DATAEN;
    logic                          WRITE_DATARDY;
    logic                          WRITE_RDY;
    logic                          WRITE_DONE;
    logic [DRAM_DATAWIDTH-1:0]     AVALON_MM_READDATA;
    logic                          AVALON_MM_READDATAVALID;
    logic                          AVALON_MM_WAITREQUEST;
    logic [DRAM_ADDRSPACE-1:0]     AVALON_MM_ADDRESS;
    logic                          AVALON_MM_READ;
    logic                          AVALON_MM_WRITE;
    logic                          AVALON_MM_WRITEACK;
    logic [DRAM_DATAWIDTH-1:0]     AVALON_MM_WRITEDATA;
    logic [DRAM_DATAWIDTH/8-1:0]   AVALON_MM_BYTEENABLE;
    logic [MAXBURST_LOG:0]         AVALON_MM_BURSTCOUNT;

    // initiator view: the burst write block itself
    modport master (
        input  WRITE_REQ, WRITE_INITADDR, WRITE_NUM, WRITE_DATA, WRITE_DATAEN,
        input  AVALON_MM_READDATA, AVALON_MM_READDATAVALID, AVALON_MM_WAITREQUEST, AVALON_MM_WRITEACK,
        output WRITE_DATARDY, WRITE_RDY, WRITE_DONE,
        output AVALON_MM_ADDRESS, AVALON_MM_READ, AVALON_MM_WRITE, AVALON_MM_WRITEDATA,
        output AVALON_MM_BYTEENABLE, AVALON_MM_BURSTCOUNT
    );

    // environment view: user logic and memory slave together
    modport slave (
        output WRITE_REQ, WRITE_INITADDR, WRITE_NUM, WRITE_DATA, WRITE_DATAEN,
        output AVALON_MM_READDATA, AVALON_MM_READDATAVALID, AVALON_MM_WAITREQUEST, AVALON_MM_WRITEACK,
        input  WRITE_DATARDY, WRITE_RDY, WRITE_DONE,
        input  AVALON_MM_ADDRESS, AVALON_MM_READ, AVALON_MM_WRITE, AVALON_MM_WRITEDATA,
        input  AVALON_MM_BYTEENABLE, AVALON_MM_BURSTCOUNT
    );
endinterface

// File: rtl/dram_write_burst.sv
// dram_write_burst: Avalon-MM burst write initiator; splits a request into bursts and waits for all write acks.
// Optional macro DRAM_WRITE_PATTERN_EN replaces the user data stream with an internal counting pattern.
module dram_write_burst #(
    parameter int MAXBURST_LOG   = 4,
    parameter int WRITENUM_SIZE  = 31,
    parameter int DRAM_ADDRSPACE = 32,
    parameter int DRAM_DATAWIDTH = 512
) (
    input  logic              clock,
    input  logic              resetn,
    dram_write_burst_if.master bus
);
    localparam int MAXBURST_NUM = 1 << MAXBURST_LOG;
    localparam int BC_W         = MAXBURST_LOG + 1;
    localparam int BN_W         = WRITENUM_SIZE - MAXBURST_LOG + 2;
    localparam int PD_W         = WRITENUM_SIZE - MAXBURST_LOG + 1;
    localparam int LANES        = DRAM_DATAWIDTH / 32;
    localparam logic [DRAM_ADDRSPACE-1:0] STRIDE = DRAM_ADDRSPACE'((DRAM_DATAWIDTH / 8) << MAXBURST_LOG);

    typedef enum logic [1:0] {IDLE, SETUP, BURST, DRAIN} state_t;

    state_t                    r_state;
    logic [DRAM_ADDRSPACE-1:0] r_addr;
    logic [BC_W-1:0]           r_burstcount;
    logic [BC_W-1:0]           r_beatcnt;
    logic [BC_W-1:0]           r_last_bc;
    logic [BN_W-1:0]           r_burstnum;
    logic [PD_W-1:0]           r_pending;
    logic                      r_done;

    logic                      w_dataen;
    logic [DRAM_DATAWIDTH-1:0] w_wdata;
    logic                      w_beat;
    logic                      w_last;
    logic                      w_dec;
    logic [PD_W-1:0]           w_pend_next;
    logic [BN_W-1:0]           w_req_bn;
    logic [BC_W-1:0]           w_req_lbc;
    logic [BC_W-1:0]           w_setup_bc;
    logic                      w_unused;

`ifdef DRAM_WRITE_PATTERN_EN
    logic [31:0] r_beatidx;

    assign w_dataen = 1'b1;
    assign w_unused = ^{bus.AVALON_MM_READDATA, bus.AVALON_MM_READDATAVALID, bus.WRITE_DATA, bus.WRITE_DATAEN};

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_wdata[32*k +: 32] = 32'(1 + k) + r_beatidx * 32'(LANES);
    end

    // beat index since the request; advances only on accepted beats
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_beatidx <= '0;
        else if (r_state == IDLE && bus.WRITE_REQ) r_beatidx <= '0;
        else if (w_beat) r_beatidx <= r_beatidx + 32'd1;
    end
`else
    assign w_dataen = bus.WRITE_DATAEN;
    assign w_wdata  = bus.WRITE_DATA;
    assign w_unused = ^{bus.AVALON_MM_READDATA, bus.AVALON_MM_READDATAVALID};
`endif

    assign w_beat      = (r_state == BURST) && w_dataen && !bus.AVALON_MM_WAITREQUEST;
    assign w_last      = w_beat && (r_beatcnt == BC_W'(1));
    assign w_dec       = bus.AVALON_MM_WRITEACK && (r_pending != '0);
    assign w_pend_next = r_pending + PD_W'(w_last) - PD_W'(w_dec);
    assign w_req_bn    = BN_W'(bus.WRITE_NUM >> MAXBURST_LOG) + BN_W'(|bus.WRITE_NUM[MAXBURST_LOG-1:0]);
    assign w_req_lbc   = (bus.WRITE_NUM[MAXBURST_LOG-1:0] == '0) ? BC_W'(MAXBURST_NUM) : BC_W'(bus.WRITE_NUM[MAXBURST_LOG-1:0]);
    assign w_setup_bc  = (r_burstnum == BN_W'(1)) ? r_last_bc : BC_W'(MAXBURST_NUM);

    // request/burst/drain sequencing with outstanding-ack tracking
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_burstcount <= '0;
            r_beatcnt    <= '0;
            r_last_bc    <= '0;
            r_burstnum   <= '0;
            r_pending    <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_pending <= w_pend_next;
            case (r_state)
                IDLE: if (bus.WRITE_REQ) begin
                    if (bus.WRITE_NUM == '0) begin
                        r_done <= 1'b1;
                    end else begin
                        r_addr     <= bus.WRITE_INITADDR;
                        r_burstnum <= w_req_bn;
                        r_last_bc  <= w_req_lbc;
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    r_burstcount <= w_setup_bc;
                    r_beatcnt    <= w_setup_bc;
                    r_state      <= BURST;
                end
                BURST: if (w_beat) begin
                    r_beatcnt <= r_beatcnt - BC_W'(1);
                    if (w_last) begin
                        r_burstnum <= r_burstnum - BN_W'(1);
                        if (r_burstnum == BN_W'(1)) begin
                            r_state <= DRAIN;
                        end else begin
                            r_addr  <= r_addr + STRIDE;
                            r_state <= SETUP;
                        end
                    end
                end
                DRAIN: if (w_pend_next == '0) begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.WRITE_RDY            = (r_state == IDLE);
    assign bus.WRITE_DONE           = r_done;
    assign bus.WRITE_DATARDY        = (r_state == BURST) && !bus.AVALON_MM_WAITREQUEST;
    assign bus.AVALON_MM_WRITE      = (r_state == BURST) && w_dataen;
    assign bus.AVALON_MM_WRITEDATA  = w_wdata;
    assign bus.AVALON_MM_ADDRESS    = r_addr;
    assign bus.AVALON_MM_BURSTCOUNT = r_burstcount;
    assign bus.AVALON_MM_READ       = 1'b0;
    assign bus.AVALON_MM_BYTEENABLE = '1;
endmodule

// File: doc/dram_write_burst.md
Name: dram_write_burst

Overview:
- Avalon-MM burst write initiator. It is the write-direction counterpart of the DRAM burst read controller used in the OpenCL RTL bandwidth tests.
- It accepts a write request (start address, beat count) and a valid/ready data stream, splits the transfer into bursts of up to 2^MAXBURST_LOG beats, and issues them to the DRAM port.
- It counts write acknowledges and signals completion only after every burst has been acknowledged.
- It sits between the user test logic of a bandwidth-write OpenCL RTL module and the AOCL global-memory Avalon-MM port.

Parameters:
MAXBURST_LOG, 4, log2 of maximum burst length in beats
WRITENUM_SIZE, 31, WRITE_NUM is WRITENUM_SIZE+1 bits (beat count)
DRAM_ADDRSPACE, 32, Avalon byte-address width
DRAM_DATAWIDTH, 512, Avalon data width in bits

Ports:
clock  in  1  single clock
resetn  in  1  reset, asynchronous, active-low
WRITE_REQ  in  1  start pulse; sampled only in IDLE
WRITE_INITADDR  in  DRAM_ADDRSPACE  byte start address, burst-aligned
WRITE_NUM  in  WRITENUM_SIZE+1  number of DRAM_DATAWIDTH beats to write
WRITE_DATA  in  DRAM_DATAWIDTH  user write data
WRITE_DATAEN  in  1  WRITE_DATA valid
WRITE_DATARDY  out  1  block accepts WRITE_DATA this cycle
WRITE_RDY  out  1  idle, may take WRITE_REQ
WRITE_DONE  out  1  one-cycle pulse, all bursts acknowledged
AVALON_MM_READDATA  in  DRAM_DATAWIDTH  unused
AVALON_MM_READDATAVALID  in  1  unused
AVALON_MM_WAITREQUEST  in  1  slave stall
AVALON_MM_ADDRESS  out  DRAM_ADDRSPACE  burst start address
AVALON_MM_READ  out  1  tied 0
AVALON_MM_WRITE  out  1  write beat strobe
AVALON_MM_WRITEACK  in  1  one pulse per completed burst
AVALON_MM_WRITEDATA  out  DRAM_DATAWIDTH  beat data
AVALON_MM_BYTEENABLE  out  DRAM_DATAWIDTH/8  all ones
AVALON_MM_BURSTCOUNT  out  MAXBURST_LOG+1  beats in current burst

Behaviour:
- Constants:
  - MAXBURST_NUM = 2^MAXBURST_LOG.
  - STRIDE = (DRAM_DATAWIDTH/8)<<MAXBURST_LOG bytes; 0x400 at defaults.
- States: IDLE, SETUP, BURST, DRAIN.
- Reset (resetn=0, async):
  - state=IDLE, address=0, burstcount=0, burstnum=0, beatcnt=0, pending=0, WRITE_DONE=0.
  - Outputs at reset: WRITE_RDY=1, WRITE_DATARDY=0, AVALON_MM_WRITE=0.
  - Reset mid-burst aborts immediately; the Avalon write strobe drops asynchronously.
- IDLE:
  - WRITE_RDY=1.
  - On WRITE_REQ with WRITE_NUM!=0:
    - latch address=WRITE_INITADDR.
    - burstnum=ceil(WRITE_NUM/MAXBURST_NUM).
    - last_burstcount = low MAXBURST_LOG bits of WRITE_NUM, or MAXBURST_NUM if those bits are 0.
    - go to SETUP.
  - On WRITE_REQ with WRITE_NUM==0: WRITE_DONE pulses the next cycle; no Avalon traffic; stay in IDLE.
- SETUP (one bubble cycle per burst):
  - burstcount = last_burstcount if burstnum==1, else MAXBURST_NUM.
  - beatcnt = the same value.
  - go to BURST.
- BURST:
  - AVALON_MM_WRITE = WRITE_DATAEN.
  - WRITE_DATARDY = !AVALON_MM_WAITREQUEST.
  - WRITEDATA = WRITE_DATA (combinational).
  - A beat is accepted when WRITE and !WAITREQUEST; beatcnt then decrements.
  - Address and burstcount are held constant for the whole burst.
  - Valid gaps (WRITE_DATAEN=0) are legal mid-burst.
  - On the last beat accepted: pending increments and burstnum decrements.
    - If burstnum was 1, go to DRAIN.
    - Otherwise address += STRIDE and go to SETUP.
- pending counter:
  - Width WRITENUM_SIZE-MAXBURST_LOG+1.
  - +1 on the last beat of each burst, −1 on WRITEACK; both in the same cycle leaves it unchanged.
  - A WRITEACK when pending==0 is ignored (no underflow).
- DRAIN:
  - When pending==0 (counting an ack arriving this cycle), assert WRITE_DONE for one cycle and go to IDLE.
  - WRITE_RDY rises together with WRITE_DONE.
- Fixed outputs: READ=0, BYTEENABLE all ones.
- WRITE_DATARDY is 0 in every state except BURST.

Optional Feature:
- Macro DRAM_WRITE_PATTERN_EN.
- Defined:
  - WRITEDATA comes from an internal generator and WRITE_DATA/WRITE_DATAEN are ignored; the block treats data as always valid.
  - Each 32-bit lane k of beat b holds 1 + b*(DRAM_DATAWIDTH/32) + k, with b counted from 0 since WRITE_REQ; this matches the read-side check pattern.
  - The generator advances only on an accepted beat and resets on WRITE_REQ.
  - WRITE_DATARDY still reports acceptance.
- Undefined: data is passed through from the user stream exactly as described in Behaviour.

Test Plan:
- N=16 at 0x1000, WAITREQUEST=0, DATAEN=1 → one burst: burstcount 16, address 0x1000, 16 WRITE beats; WRITEACK 5 cycles later → WRITE_DONE one cycle after ack, WRITE_RDY=1.
- N=37 at 0x0 → bursts 16,16,5 at 0x0,0x400,0x800, each preceded by one SETUP bubble; 3 acks, issued early or late → DONE only after the third ack.
- WAITREQUEST high 3 cycles on beat 4 → WRITEDATA, address and burstcount held; DATARDY=0 during stall; no beat lost or duplicated (scoreboard 16 beats).
- DATAEN toggling every other cycle, N=8 → WRITE follows DATAEN; burst completes after 8 accepted beats; burstcount stays 8.
- N=0 → WRITE_DONE next cycle, AVALON_MM_WRITE never asserted; resetn low mid-burst (beat 7 of 16) → WRITE drops immediately, WRITE_RDY=1, new N=4 request runs cleanly.
- DRAM_WRITE_PATTERN_EN defined, N=3 → lane0 of beats = 1, 17, 33; lane15 of beat 0 = 16.
